// File: rtl/tx_req_demux.sv
// rtl/tx_req_demux.sv - request demux to PORTS transmit engines with N:1 status merge

// One status channel: a FIFO per port feeding a round-robin merge into a registered pulse.
module tx_req_demux_status_merge #(
    parameter int PORTS = 2,
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PORTS-1:0]        i_valid,
    input  logic [PORTS-1:0][W-1:0] i_data,
    output logic                    o_valid,
    output logic [W-1:0]            o_data,
    output logic                    o_overflow
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

    logic [W-1:0]           r_mem [PORTS][1<<AW];
    logic [PORTS-1:0][AW:0] r_wr;
    logic [PORTS-1:0][AW:0] r_rd;
    logic [PW-1:0]          r_rr;
    logic [PORTS-1:0]       w_full;
    logic [PORTS-1:0]       w_nonempty;
    logic [PORTS-1:0]       w_push;
    logic                   w_grant_valid;
    logic [PW-1:0]          w_grant;
    int                     w_idx;

    // Per-port FIFO occupancy; a write into a full FIFO is dropped and flagged
    always_comb begin
        w_nonempty = '0;
        w_full     = '0;
        w_push     = '0;
        for (int p = 0; p < PORTS; p++) begin
            w_nonempty[p] = (r_wr[p] != r_rd[p]);
            w_full[p]     = (r_wr[p][AW] != r_rd[p][AW]) &&
                            (r_wr[p][AW-1:0] == r_rd[p][AW-1:0]);
            w_push[p]     = i_valid[p] && !w_full[p];
        end
    end

    assign o_overflow = |(i_valid & w_full);

    // Round-robin search for the first non-empty FIFO starting at r_rr
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant       = '0;
        w_idx         = 0;
        for (int k = 0; k < PORTS; k++) begin
            w_idx = (int'(r_rr) + k) % PORTS;
            if (!w_grant_valid && w_nonempty[w_idx]) begin
                w_grant_valid = 1'b1;
                w_grant       = PW'(w_idx);
            end
        end
    end

    // FIFO payload storage, written whenever the port's status valid is accepted
    always_ff @(posedge clk) begin
        for (int p = 0; p < PORTS; p++) begin
            if (w_push[p]) begin
                r_mem[p][r_wr[p][AW-1:0]] <= i_data[p];
            end
        end
    end

    // Pointers, RR pointer and the single-cycle output pulse register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_rr    <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            for (int p = 0; p < PORTS; p++) begin
                if (w_push[p]) begin
                    r_wr[p] <= r_wr[p] + 1'b1;
                end
                if (w_grant_valid && (w_grant == PW'(p))) begin
                    r_rd[p] <= r_rd[p] + 1'b1;
                end
            end
            o_valid <= w_grant_valid;
            if (w_grant_valid) begin
                o_data <= r_mem[w_grant][r_rd[w_grant][AW-1:0]];
                r_rr   <= (int'(w_grant) + 1 >= PORTS) ? '0 : w_grant + PW'(1);
            end
        end
    end
endmodule

// Request demux with per-port credits plus three merged status channels.
module tx_req_demux #(
    parameter int PORTS             = 2,
    parameter int QUEUE_INDEX_WIDTH = 4,
    parameter int REQ_TAG_WIDTH     = 8,
    parameter int S_DEST_WIDTH      = 8,
    parameter int CL_PORTS          = $clog2(PORTS),
    parameter int M_DEST_WIDTH      = S_DEST_WIDTH - CL_PORTS,
    parameter int LEN_WIDTH         = 20,
    parameter int MAX_OUTSTANDING   = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [QUEUE_INDEX_WIDTH-1:0]       s_axis_req_queue,
    input  logic [REQ_TAG_WIDTH-1:0]           s_axis_req_tag,
    input  logic [S_DEST_WIDTH-1:0]            s_axis_req_dest,
    input  logic                               s_axis_req_valid,
    output logic                               s_axis_req_ready,
    output logic [PORTS*QUEUE_INDEX_WIDTH-1:0] m_axis_req_queue,
    output logic [PORTS*REQ_TAG_WIDTH-1:0]     m_axis_req_tag,
    output logic [PORTS*M_DEST_WIDTH-1:0]      m_axis_req_dest,
    output logic [PORTS-1:0]                   m_axis_req_valid,
    input  logic [PORTS-1:0]                   m_axis_req_ready,
    input  logic [PORTS-1:0]                   s_axis_status_dequeue_empty,
    input  logic [PORTS-1:0]                   s_axis_status_dequeue_error,
    input  logic [PORTS*QUEUE_INDEX_WIDTH-1:0] s_axis_status_dequeue_queue,
    input  logic [PORTS*REQ_TAG_WIDTH-1:0]     s_axis_status_dequeue_tag,
    input  logic [PORTS-1:0]                   s_axis_status_dequeue_valid,
    input  logic [PORTS-1:0]                   s_axis_status_start_error,
    input  logic [PORTS*LEN_WIDTH-1:0]         s_axis_status_start_len,
    input  logic [PORTS*QUEUE_INDEX_WIDTH-1:0] s_axis_status_start_queue,
    input  logic [PORTS*REQ_TAG_WIDTH-1:0]     s_axis_status_start_tag,
    input  logic [PORTS-1:0]                   s_axis_status_start_valid,
    input  logic [PORTS*LEN_WIDTH-1:0]         s_axis_status_finish_len,
    input  logic [PORTS*QUEUE_INDEX_WIDTH-1:0] s_axis_status_finish_queue,
    input  logic [PORTS*REQ_TAG_WIDTH-1:0]     s_axis_status_finish_tag,
    input  logic [PORTS-1:0]                   s_axis_status_finish_valid,
    output logic                               m_axis_status_dequeue_empty,
    output logic                               m_axis_status_dequeue_error,
    output logic [QUEUE_INDEX_WIDTH-1:0]       m_axis_status_dequeue_queue,
    output logic [REQ_TAG_WIDTH-1:0]           m_axis_status_dequeue_tag,
    output logic                               m_axis_status_dequeue_valid,
    output logic                               m_axis_status_start_error,
    output logic [LEN_WIDTH-1:0]               m_axis_status_start_len,
    output logic [QUEUE_INDEX_WIDTH-1:0]       m_axis_status_start_queue,
    output logic [REQ_TAG_WIDTH-1:0]           m_axis_status_start_tag,
    output logic                               m_axis_status_start_valid,
    output logic [LEN_WIDTH-1:0]               m_axis_status_finish_len,
    output logic [QUEUE_INDEX_WIDTH-1:0]       m_axis_status_finish_queue,
    output logic [REQ_TAG_WIDTH-1:0]           m_axis_status_finish_tag,
    output logic                               m_axis_status_finish_valid
);
    localparam int QI    = QUEUE_INDEX_WIDTH;
    localparam int TW    = REQ_TAG_WIDTH;
    localparam int LW    = LEN_WIDTH;
    localparam int SEL_W = (CL_PORTS > 0) ? CL_PORTS : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int DQ_W  = 2 + QI + TW;
    localparam int ST_W  = 1 + LW + QI + TW;
    localparam int FN_W  = LW + QI + TW;

    logic                               r_live;
    logic                               r_err;
    logic                               r_in_valid;
    logic [QI-1:0]                      r_in_queue;
    logic [TW-1:0]                      r_in_tag;
    logic [M_DEST_WIDTH-1:0]            r_in_dest;
    logic [SEL_W-1:0]                   r_in_sel;
    logic [PORTS-1:0]                   r_out_valid;
    logic [PORTS-1:0][QI-1:0]           r_out_queue;
    logic [PORTS-1:0][TW-1:0]           r_out_tag;
    logic [PORTS-1:0][M_DEST_WIDTH-1:0] r_out_dest;
    logic [PORTS-1:0][CNT_W-1:0]        r_out_cnt;

    logic [SEL_W-1:0]                   w_s_sel;
    logic [PORTS-1:0]                   w_slot_ok;
    logic [PORTS-1:0]                   w_load;
    logic                               w_in_move;
    logic                               w_s_fire;
    logic                               w_direct;
    logic [QI-1:0]                      w_ld_queue;
    logic [TW-1:0]                      w_ld_tag;
    logic [M_DEST_WIDTH-1:0]            w_ld_dest;
    logic [PORTS-1:0][CNT_W-1:0]        w_dec;
    logic [PORTS-1:0][CNT_W-1:0]        w_cnt_sum;
    logic [PORTS-1:0][CNT_W-1:0]        w_cnt_next;
    logic [PORTS-1:0]                   w_uf;
    logic [PORTS-1:0][DQ_W-1:0]         w_dq_data;
    logic [PORTS-1:0][ST_W-1:0]         w_st_data;
    logic [PORTS-1:0][FN_W-1:0]         w_fn_data;
    logic [DQ_W-1:0]                    w_dq_out;
    logic [ST_W-1:0]                    w_st_out;
    logic [FN_W-1:0]                    w_fn_out;
    logic                               w_dq_ovf;
    logic                               w_st_ovf;
    logic                               w_fn_ovf;

    // Engine select from the top dest bits; out-of-range selects go to the last port
    generate
        if (CL_PORTS == 0) begin : g_nosel
            assign w_s_sel = '0;
        end else if ((1 << CL_PORTS) > PORTS) begin : g_clamp
            logic [CL_PORTS-1:0] w_raw;
            assign w_raw   = s_axis_req_dest[S_DEST_WIDTH-1 -: CL_PORTS];
            assign w_s_sel = (w_raw >= CL_PORTS'(PORTS - 1)) ? CL_PORTS'(PORTS - 1) : w_raw;
        end else begin : g_sel
            assign w_s_sel = s_axis_req_dest[S_DEST_WIDTH-1 -: CL_PORTS];
        end
    endgenerate

    // A port can take a request when its output slot is empty or draining and it has credit
    always_comb begin
        w_slot_ok = '0;
        w_load    = '0;
        for (int p = 0; p < PORTS; p++) begin
            w_slot_ok[p] = (!r_out_valid[p] || m_axis_req_ready[p]) &&
                           (r_out_cnt[p] < CNT_W'(MAX_OUTSTANDING));
        end
        for (int p = 0; p < PORTS; p++) begin
            w_load[p] = (w_in_move && (r_in_sel == SEL_W'(p))) ||
                        (w_direct && (w_s_sel == SEL_W'(p)));
        end
    end

    assign w_in_move        = r_in_valid && w_slot_ok[r_in_sel];
    assign s_axis_req_ready = r_live && (!r_in_valid || w_in_move);
    assign w_s_fire         = s_axis_req_valid && s_axis_req_ready;
    assign w_direct         = w_s_fire && !r_in_valid && w_slot_ok[w_s_sel];
    assign w_ld_queue       = r_in_valid ? r_in_queue : s_axis_req_queue;
    assign w_ld_tag         = r_in_valid ? r_in_tag   : s_axis_req_tag;
    assign w_ld_dest        = r_in_valid ? r_in_dest  : s_axis_req_dest[M_DEST_WIDTH-1:0];

    // Holding register: used only when a new request cannot go straight to its port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live     <= 1'b0;
            r_in_valid <= 1'b0;
            r_in_queue <= '0;
            r_in_tag   <= '0;
            r_in_dest  <= '0;
            r_in_sel   <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_s_fire && !w_direct) begin
                r_in_valid <= 1'b1;
                r_in_queue <= s_axis_req_queue;
                r_in_tag   <= s_axis_req_tag;
                r_in_dest  <= s_axis_req_dest[M_DEST_WIDTH-1:0];
                r_in_sel   <= w_s_sel;
            end else if (w_in_move) begin
                r_in_valid <= 1'b0;
            end
        end
    end

    // Per-port output registers; data held stable until the engine accepts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= '0;
            r_out_queue <= '0;
            r_out_tag   <= '0;
            r_out_dest  <= '0;
        end else begin
            for (int p = 0; p < PORTS; p++) begin
                if (w_load[p]) begin
                    r_out_valid[p] <= 1'b1;
                    r_out_queue[p] <= w_ld_queue;
                    r_out_tag[p]   <= w_ld_tag;
                    r_out_dest[p]  <= w_ld_dest;
                end else if (m_axis_req_ready[p]) begin
                    r_out_valid[p] <= 1'b0;
                end
            end
        end
    end

    assign m_axis_req_valid = r_out_valid;
    assign m_axis_req_queue = r_out_queue;
    assign m_axis_req_tag   = r_out_tag;
    assign m_axis_req_dest  = r_out_dest;

    // Status payload packing and count of terminating statuses per port this cycle
    always_comb begin
        w_dq_data = '0;
        w_st_data = '0;
        w_fn_data = '0;
        w_dec     = '0;
        for (int p = 0; p < PORTS; p++) begin
            w_dq_data[p] = {s_axis_status_dequeue_empty[p], s_axis_status_dequeue_error[p],
                            s_axis_status_dequeue_queue[p*QI +: QI],
                            s_axis_status_dequeue_tag[p*TW +: TW]};
            w_st_data[p] = {s_axis_status_start_error[p], s_axis_status_start_len[p*LW +: LW],
                            s_axis_status_start_queue[p*QI +: QI],
                            s_axis_status_start_tag[p*TW +: TW]};
            w_fn_data[p] = {s_axis_status_finish_len[p*LW +: LW],
                            s_axis_status_finish_queue[p*QI +: QI],
                            s_axis_status_finish_tag[p*TW +: TW]};
            w_dec[p]     = CNT_W'(s_axis_status_dequeue_valid[p] &&
                                  (s_axis_status_dequeue_empty[p] || s_axis_status_dequeue_error[p])) +
                           CNT_W'(s_axis_status_start_valid[p] && s_axis_status_start_error[p]) +
                           CNT_W'(s_axis_status_finish_valid[p]);
        end
    end

    // Next credit count: add the issued request, subtract terminations, floor at zero
    always_comb begin
        w_cnt_sum  = '0;
        w_cnt_next = '0;
        w_uf       = '0;
        for (int p = 0; p < PORTS; p++) begin
            w_cnt_sum[p] = r_out_cnt[p] + CNT_W'(w_load[p]);
            if (w_cnt_sum[p] >= w_dec[p]) begin
                w_cnt_next[p] = w_cnt_sum[p] - w_dec[p];
            end else begin
                w_cnt_next[p] = '0;
                w_uf[p]       = 1'b1;
            end
        end
    end

    // Credit counters and the sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            r_out_cnt <= w_cnt_next;
            r_err     <= r_err | (|w_uf) | w_dq_ovf | w_st_ovf | w_fn_ovf;
        end
    end

    // Credit underflow or status FIFO overflow indicates a misbehaving engine
    assert property (@(posedge clk) disable iff (rst) !r_err);

    tx_req_demux_status_merge #(.PORTS(PORTS), .W(DQ_W), .DEPTH(MAX_OUTSTANDING)) u_dq_merge (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (s_axis_status_dequeue_valid),
        .i_data     (w_dq_data),
        .o_valid    (m_axis_status_dequeue_valid),
        .o_data     (w_dq_out),
        .o_overflow (w_dq_ovf)
    );

    tx_req_demux_status_merge #(.PORTS(PORTS), .W(ST_W), .DEPTH(MAX_OUTSTANDING)) u_st_merge (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (s_axis_status_start_valid),
        .i_data     (w_st_data),
        .o_valid    (m_axis_status_start_valid),
        .o_data     (w_st_out),
        .o_overflow (w_st_ovf)
    );

    tx_req_demux_status_merge #(.PORTS(PORTS), .W(FN_W), .DEPTH(MAX_OUTSTANDING)) u_fn_merge (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (s_axis_status_finish_valid),
        .i_data     (w_fn_data),
        .o_valid    (m_axis_status_finish_valid),
        .o_data     (w_fn_out),
        .o_overflow (w_fn_ovf)
    );

    assign {m_axis_status_dequeue_empty, m_axis_status_dequeue_error,
            m_axis_status_dequeue_queue, m_axis_status_dequeue_tag} = w_dq_out;
    assign {m_axis_status_start_error, m_axis_status_start_len,
            m_axis_status_start_queue, m_axis_status_start_tag} = w_st_out;
    assign {m_axis_status_finish_len, m_axis_status_finish_queue,
            m_axis_status_finish_tag} = w_fn_out;
endmodule
